// File: rtl/adder_pkg.sv
// Shared definitions for the settle-scheduled adder front end.
// Contents: FSM state encoding and default operand width / settle time.
package adder_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StHold   = 2'd2
    } state_e;

    localparam int unsigned DefWidth        = 4;
    localparam int unsigned DefSettleCycles = 3;

endpackage

// File: rtl/adder_settle_sched_if.sv
// Bundle of all handshake and adder-side signals of adder_settle_sched.
// slave  : seen by adder_settle_sched (requests in, adder operands out, response out).
// master : seen by the environment (requesters, external adder, response consumer).
interface adder_settle_sched_if
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) ();

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ci;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ci;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_ci;
    logic [WIDTH-1:0] add_sum;
    logic             add_co;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_co;
    logic             rsp_id;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ci,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ci,
        output req1_ready,
        output add_a, add_b, add_ci,
        input  add_sum, add_co,
        output rsp_valid, rsp_sum, rsp_co, rsp_id,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ci,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ci,
        input  req1_ready,
        input  add_a, add_b, add_ci,
        output add_sum, add_co,
        input  rsp_valid, rsp_sum, rsp_co, rsp_id,
        output rsp_ready,
        input  busy
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// valid_i : request vector {req1, req0}
// last_i  : index granted most recently; on a tie the other requester wins
// grant_o : one-hot grant (zero when nobody requests)
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/adder_settle_sched.sv
// Shares one external combinational adder between two requesters.
// The granted operands are registered onto add_a/add_b/add_ci and held for SETTLE_CYCLES
// clocks so the slow ripple adder can settle, then add_sum/add_co are captured into rsp_*.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : request, adder and response signals (slave modport of adder_settle_sched_if)
// Legal SETTLE_CYCLES: 1..15.
module adder_settle_sched
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH         = DefWidth,
    parameter int unsigned SETTLE_CYCLES = DefSettleCycles
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_settle_sched_if.slave   bus
);

    localparam int unsigned    CntW    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(SETTLE_CYCLES);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             add_ci_q, add_ci_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_co_q, rsp_co_d;
    logic             rsp_id_q, rsp_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             last_q, last_d;
    logic [1:0]       grant;
    logic             idle;

    rr_arb2 u_arb (
        .valid_i (
            {bus.req1_valid, bus.req0_valid}),
        .last_i  (last_q),
        .grant_o (grant)
    );

    assign idle = (state_q == StIdle);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_ci_d    = add_ci_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_co_d    = rsp_co_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        last_d      = last_q;
        case (state_q)
            StIdle: begin
                if (grant != 2'b00) begin
                    state_d  = StSettle;
                    cnt_d    = CntInit;
                    add_a_d  = grant[1] ? bus.req1_a  : bus.req0_a;
                    add_b_d  = grant[1] ? bus.req1_b  : bus.req0_b;
                    add_ci_d = grant[1] ? bus.req1_ci : bus.req0_ci;
                    rsp_id_d = grant[1];
                    last_d   = grant[1];
                end
            end
            StSettle: begin
                // Adder inputs have been stable for SETTLE_CYCLES clocks once cnt hits 1.
                if (cnt_q == CntOne) begin
                    state_d     = StHold;
                    cnt_d       = '0;
                    rsp_sum_d   = bus.add_sum;
                    rsp_co_d    = bus.add_co;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StHold: begin
                if (bus.rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_ci_q    <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_co_q    <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_ci_q    <= add_ci_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_co_q    <= rsp_co_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            last_q      <= last_d;
        end
    end

    assign bus.req0_ready = idle && grant[0];
    assign bus.req1_ready = idle && grant[1];
    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;
    assign bus.add_ci     = add_ci_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_sum    = rsp_sum_q;
    assign bus.rsp_co     = rsp_co_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.busy       = !idle;

endmodule
